pulse_train_gen: RTL

- Parametrised successor to the single-echo pulse generator.
- Produces a repeating spin-echo / CPMG train: one excitation pulse, then up to 2^NW-1 refocusing pulses spaced 2*delay. Also drives a per-period sync pulse, a receiver-inhibit window and attenuator codes that switch between pulse and receive values.
- Configuration is written as a pending bundle and takes effect only at a period boundary, so a running train is never corrupted.

---
 rtl/pulse_train_gen.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: repeating spin-echo / CPMG pulse train with a per-period
// sync pulse, receiver-inhibit window and pulse/receive attenuator switching.
// Configuration is double-buffered: cfg_load fills a pending bundle that is
// copied to the active bundle only at a period boundary.
// Optional feature macro: PULSE_TRAIN_PHASE_EN adds a 2-bit phase-cycling
// index output that advances at every boundary that starts a new period.
module pulse_train_gen #(
    parameter int CW     = 32,
    parameter int NW     = 8,
    parameter int ATT_W  = 7,
    parameter int SYNC_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             cfg_load,
    input  logic [CW-1:0]    cfg_period,
    input  logic [CW-1:0]    cfg_p1width,
    input  logic [CW-1:0]    cfg_p2width,
    input  logic [CW-1:0]    cfg_delay,
    input  logic [NW-1:0]    cfg_cpmg,
    input  logic             cfg_block,
    input  logic [CW-1:0]    cfg_block_off,
    input  logic [ATT_W-1:0] cfg_pre_att,
    input  logic [ATT_W-1:0] cfg_post_att,
    output logic             pulse_on,
    output logic             sync_on,
    output logic             inhib,
    output logic [ATT_W-1:0] att,
    output logic             cfg_pending,
    output logic             overrun,
    output logic [NW-1:0]    echo_cnt
`ifdef PULSE_TRAIN_PHASE_EN
    ,
    output logic [1:0]       phase
`endif
);

    typedef struct packed {
        logic [CW-1:0]    period;
        logic [CW-1:0]    p1;
        logic [CW-1:0]    p2;
        logic [CW-1:0]    delay;
        logic [NW-1:0]    cpmg;
        logic             block;
        logic [CW-1:0]    block_off;
        logic [ATT_W-1:0] pre_att;
        logic [ATT_W-1:0] post_att;
    } cfg_t;

    typedef enum logic [2:0] {IDLE, PULSE1, WAIT1, PULSE2, WAIT2, TAIL, HOLD} state_t;

    // Sequence position: state plus refocusing pulses issued so far.
    typedef struct packed {
        state_t        st;
        logic [NW-1:0] ec;
    } seq_t;

    cfg_t          cfg_in, act_q, act_d, pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    state_t        state_q, state_d;
    logic [NW-1:0] echo_q, echo_d;
    logic [CW-1:0] pcnt_q, pcnt_d, per_m1;
    logic [CW:0]   cnt_q, cnt_d;
    logic          overrun_q, overrun_d;
    logic          pulse_on_q, pulse_on_d, sync_q, sync_d, inhib_q, inhib_d;
    logic [ATT_W-1:0] att_q, att_d;
    logic          active, done, bnd;
    seq_t          cur, seq_nxt, seq_start;
`ifdef PULSE_TRAIN_PHASE_EN
    logic [1:0]    phase_q, phase_d;
`endif

    assign cfg_in = '{cfg_period, cfg_p1width, cfg_p2width, cfg_delay, cfg_cpmg,
                      cfg_block, cfg_block_off, cfg_pre_att, cfg_post_att};

    // Cycles spent in each timed state; IDLE/HOLD never time out.
    function automatic logic [CW:0] state_len(state_t s, cfg_t c);
        case (s)
            PULSE1:  return {1'b0, c.p1};
            WAIT1:   return {1'b0, c.delay};
            PULSE2:  return {1'b0, c.p2};
            WAIT2:   return {c.delay, 1'b0};
            TAIL:    return {1'b0, c.block_off};
            default: return '1;
        endcase
    endfunction

    // Successor of a state that has just finished; echo counts on PULSE2 entry.
    function automatic seq_t step(seq_t s, cfg_t c);
        seq_t r;
        r = s;
        case (s.st)
            PULSE1: r.st = WAIT1;
            WAIT1: begin
                if (c.cpmg == '0) r.st = TAIL;
                else begin
                    r.st = PULSE2;
                    r.ec = s.ec + 1'b1;
                end
            end
            PULSE2: begin
                if (s.ec == c.cpmg) r.st = TAIL;
                else if (c.p2 == '0 && c.delay == '0) begin
                    // all remaining echoes are zero-length: account for them at once
                    r.st = TAIL;
                    r.ec = c.cpmg;
                end else r.st = WAIT2;
            end
            WAIT2: begin
                r.st = PULSE2;
                r.ec = s.ec + 1'b1;
            end
            TAIL:    r.st = HOLD;
            default: r = s;
        endcase
        return r;
    endfunction

    // Walk through zero-length states so none of them costs a cycle.
    function automatic seq_t resolve(seq_t s, cfg_t c);
        seq_t r;
        r = s;
        for (int i = 0; i < 6; i++)
            if (state_len(r.st, c) == '0) r = step(r, c);
        return r;
    endfunction

    // Next-state: period counter, boundary handling, sequencer and output decode.
    always_comb begin
        act_d     = act_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        state_d   = state_q;
        echo_d    = echo_q;
        pcnt_d    = pcnt_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
`ifdef PULSE_TRAIN_PHASE_EN
        phase_d   = phase_q;
`endif
        cur       = '{st: state_q, ec: echo_q};
        seq_start = '{st: PULSE1, ec: '0};
        active    = state_q inside {PULSE1, WAIT1, PULSE2, WAIT2, TAIL};
        done      = active && (cnt_q == state_len(state_q, act_q) - 1'b1);
        seq_nxt   = done ? resolve(step(cur, act_q), act_q) : cur;
        per_m1    = (act_q.period < CW'(2)) ? CW'(1) : act_q.period - 1'b1;
        bnd       = (state_q == IDLE) || (pcnt_q == per_m1);

        if (cfg_load) begin
            pend_d   = cfg_in;
            pend_v_d = 1'b1;
        end

        if (bnd) begin
            if (pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = cfg_load;    // a load on the boundary waits for the next one
            end
            if (state_q != IDLE && seq_nxt.st != HOLD) overrun_d = 1'b1;
            pcnt_d = '0;
            cnt_d  = '0;
            if (run) begin
                seq_start = resolve(seq_start, act_d);
                state_d   = seq_start.st;
                echo_d    = seq_start.ec;
`ifdef PULSE_TRAIN_PHASE_EN
                phase_d   = phase_q + 1'b1;
`endif
            end else begin
                state_d = IDLE;
                echo_d  = '0;
            end
        end else begin
            pcnt_d  = pcnt_q + 1'b1;
            state_d = seq_nxt.st;
            echo_d  = seq_nxt.ec;
            if (done) cnt_d = '0;
            else if (active) cnt_d = cnt_q + 1'b1;
        end

        pulse_on_d = state_d inside {PULSE1, PULSE2};
        inhib_d    = act_d.block && (state_d inside {PULSE1, WAIT1, PULSE2, WAIT2, TAIL});
        att_d      = inhib_d ? act_d.pre_att : act_d.post_att;
        sync_d     = (state_d != IDLE) && (pcnt_d < CW'(SYNC_W));
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            act_q      <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            state_q    <= IDLE;
            echo_q     <= '0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            pulse_on_q <= 1'b0;
            sync_q     <= 1'b0;
            inhib_q    <= 1'b0;
            att_q      <= '0;
`ifdef PULSE_TRAIN_PHASE_EN
            phase_q    <= '0;
`endif
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            state_q    <= state_d;
            echo_q     <= echo_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            pulse_on_q <= pulse_on_d;
            sync_q     <= sync_d;
            inhib_q    <= inhib_d;
            att_q      <= att_d;
`ifdef PULSE_TRAIN_PHASE_EN
            phase_q    <= phase_d;
`endif
        end
    end

    assign pulse_on    = pulse_on_q;
    assign sync_on     = sync_q;
    assign inhib       = inhib_q;
    assign att         = att_q;
    assign cfg_pending = pend_v_q;
    assign overrun     = overrun_q;
    assign echo_cnt    = echo_q;
`ifdef PULSE_TRAIN_PHASE_EN
    assign phase       = phase_q;
`endif

endmodule
